cam_stream_gen: RTL and testbench

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

---
 rtl/cam_stream_gen.sv | 205 ++++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// Camera-style stream generator: pixel clock, vsync/href framing and test patterns.
// Define CAM_STREAM_GEN_CRC_EN to add a per-frame CRC-16-CCITT on crc_o.
module cam_stream_gen #(
  parameter int HRES        = 640,
  parameter int VRES        = 480,
  parameter int DATA_W      = 8,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int HBLANK      = 144
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  output logic              cam_clk_o,
  output logic              cam_vsync_o,
  output logic              cam_href_o,
  output logic [DATA_W-1:0] cam_data_o,
  output logic [15:0]       frame_cnt_o,
  output logic              frame_done_o,
  output logic [15:0]       crc_o
);

  // state    | meaning
  // S_IDLE   | stream stopped, waiting for en_i on a pixel tick
  // S_VSYNC  | vsync high for VSYNC_LINES line periods
  // S_VBP    | vertical back porch
  // S_LINE   | href high, pattern bytes on cam_data_o
  // S_HBLANK | href low between active lines
  // S_VFP    | vertical front porch; frame completes on exit
  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] col_q, col_d;
  logic [15:0] line_q, line_d;
  logic [15:0] frame_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic        byte_q, byte_d;
  logic        done_d;
  logic        start_frame;
  logic        tick;

  logic [2:0]        bar;
  logic [15:0]       rgb_pix;
  logic [7:0]        rgb_byte;
  logic [DATA_W-1:0] pix_data;

  // Pixel tick is the clk_i edge on which cam_clk_o falls.
  assign tick = cam_clk_o;

  // Timing parameters are expected to be >= 1 line (porches/vsync).
  function automatic logic [15:0] lines_to_ticks(input int lines, input logic rgb);
    int tl;
    tl = rgb ? (2 * HRES + HBLANK) : (HRES + HBLANK);
    return 16'(lines * tl - 1);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    line_d      = line_q;
    byte_d      = byte_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_o;
    done_d      = 1'b0;
    start_frame = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (en_i) start_frame = 1'b1;
        end
        S_VSYNC: begin
          if (cnt_q == 16'd0) begin
            state_d = S_VBP;
            cnt_d   = lines_to_ticks(VBP_LINES, mode_q == 2'd0);
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_VBP: begin
          if (cnt_q == 16'd0) state_d = S_LINE;
          else                cnt_d   = cnt_q - 16'd1;
        end
        S_LINE: begin
          if (mode_q == 2'd0 && !byte_q) begin
            byte_d = 1'b1;
          end else begin
            byte_d = 1'b0;
            if (col_q == 16'(HRES - 1)) begin
              col_d = 16'd0;
              if (line_q == 16'(VRES - 1)) begin
                line_d  = 16'd0;
                state_d = S_VFP;
                cnt_d   = lines_to_ticks(VFP_LINES, mode_q == 2'd0);
              end else begin
                line_d  = line_q + 16'd1;
                state_d = (HBLANK == 0) ? S_LINE : S_HBLANK;
                cnt_d   = 16'(HBLANK - 1);
              end
            end else begin
              col_d = col_q + 16'd1;
            end
          end
        end
        S_HBLANK: begin
          if (cnt_q == 16'd0) state_d = S_LINE;
          else                cnt_d   = cnt_q - 16'd1;
        end
        S_VFP: begin
          if (cnt_q == 16'd0) begin
            frame_cnt_d = frame_cnt_o + 16'd1;
            done_d      = 1'b1;
            state_d     = S_IDLE;
            if (en_i) start_frame = 1'b1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Mode is sampled only at frame start so a frame never mixes patterns.
      if (start_frame) begin
        state_d = S_VSYNC;
        mode_d  = mode_i;
        cnt_d   = lines_to_ticks(VSYNC_LINES, mode_i == 2'd0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cam_clk_o    <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      col_q        <= '0;
      line_q       <= '0;
      byte_q       <= 1'b0;
      mode_q       <= '0;
      frame_cnt_o  <= '0;
      frame_done_o <= 1'b0;
    end else begin
      cam_clk_o    <= ~cam_clk_o;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      line_q       <= line_d;
      byte_q       <= byte_d;
      mode_q       <= mode_d;
      frame_cnt_o  <= frame_cnt_d;
      frame_done_o <= done_d;
    end
  end

  always_comb begin
    bar      = 3'((32'(col_q) * 8) / HRES);
    rgb_pix  = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
    rgb_byte = byte_q ? rgb_pix[7:0] : rgb_pix[15:8];
    pix_data = '0;
    if (state_q == S_LINE) begin
      unique case (mode_q)
        2'd0:    pix_data = DATA_W'(rgb_byte) << (DATA_W - 8);
        2'd2:    pix_data = {DATA_W{col_q[3] ^ line_q[3]}};
        default: pix_data = DATA_W'(col_q + line_q + frame_cnt_o);
      endcase
    end
  end

  assign cam_data_o  = pix_data;
  assign cam_vsync_o = (state_q == S_VSYNC);
  assign cam_href_o  = (state_q == S_LINE);

`ifdef CAM_STREAM_GEN_CRC_EN
  logic [15:0] crc_q;
  logic [7:0]  crc_byte;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Wide RAW buses contribute only their low byte.
  assign crc_byte = (mode_q == 2'd0) ? rgb_byte : pix_data[7:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= 16'hFFFF;
      crc_o <= '0;
    end else begin
      if (start_frame)                    crc_q <= 16'hFFFF;
      else if (tick && state_q == S_LINE) crc_q <= crc16_step(crc_q, crc_byte);
      if (done_d) crc_o <= crc_q;
    end
  end
`else
  assign crc_o = '0;
`endif

endmodule

// File: tb/tb_cam_stream_gen.sv
// Scoreboard bench for cam_stream_gen: three parameterisations share clock and reset.
module tb_cam_stream_gen;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } item_t;

  logic clk, rst_n;
  logic ea, eb, ec;
  logic [1:0] ma, mb, mc;

  logic a_cclk, a_vs, a_hr, a_done; logic [7:0] a_d; logic [15:0] a_fc, a_crc;
  logic b_cclk, b_vs, b_hr, b_done; logic [7:0] b_d; logic [15:0] b_fc, b_crc;
  logic c_cclk, c_vs, c_hr, c_done; logic [7:0] c_d; logic [15:0] c_fc, c_crc;

  int n_chk = 0;
  int n_fail = 0;

  item_t       qa[$];
  logic [7:0]  qb[$], qc[$];
  logic [15:0] qfc_a[$], qfc_b[$], qfc_c[$], qcrc[$];

  cam_stream_gen #(.HRES(4), .VRES(2), .DATA_W(8), .VSYNC_LINES(1), .VBP_LINES(1),
                   .VFP_LINES(1), .HBLANK(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(ea), .mode_i(ma), .cam_clk_o(a_cclk),
    .cam_vsync_o(a_vs), .cam_href_o(a_hr), .cam_data_o(a_d), .frame_cnt_o(a_fc),
    .frame_done_o(a_done), .crc_o(a_crc));

  cam_stream_gen #(.HRES(8), .VRES(2), .DATA_W(8), .VSYNC_LINES(1), .VBP_LINES(1),
                   .VFP_LINES(1), .HBLANK(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(eb), .mode_i(mb), .cam_clk_o(b_cclk),
    .cam_vsync_o(b_vs), .cam_href_o(b_hr), .cam_data_o(b_d), .frame_cnt_o(b_fc),
    .frame_done_o(b_done), .crc_o(b_crc));

  cam_stream_gen #(.HRES(16), .VRES(16), .DATA_W(8), .VSYNC_LINES(1), .VBP_LINES(1),
                   .VFP_LINES(1), .HBLANK(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(ec), .mode_i(mc), .cam_clk_o(c_cclk),
    .cam_vsync_o(c_vs), .cam_href_o(c_hr), .cam_data_o(c_d), .frame_cnt_o(c_fc),
    .frame_done_o(c_done), .crc_o(c_crc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // One A frame: 6 vsync, 6 back porch, line0, 2 blank, line1, 6 front porch.
  task automatic push_a_frame(input logic [31:0] l0, input logic [31:0] l1);
    repeat (6) qa.push_back({1'b1, 1'b0, 8'h00});
    repeat (6) qa.push_back({1'b0, 1'b0, 8'h00});
    for (int c = 0; c < 4; c++) qa.push_back({1'b0, 1'b1, l0[8*c +: 8]});
    repeat (2) qa.push_back({1'b0, 1'b0, 8'h00});
    for (int c = 0; c < 4; c++) qa.push_back({1'b0, 1'b1, l1[8*c +: 8]});
    repeat (6) qa.push_back({1'b0, 1'b0, 8'h00});
  endtask

  task automatic wait_ev(input int sel, input int budget, input string nm);
    bit hit;
    int i;
    hit = 1'b0;
    i = 0;
    while (!hit && i < budget) begin
      @(negedge clk);
      i++;
      case (sel)
        0: hit = a_done;
        1: hit = a_hr;
        2: hit = a_vs;
        3: hit = b_done;
        4: hit = b_vs;
        default: hit = c_done;
      endcase
    end
    if (!hit) chk(nm, 32'd0, 32'd1);
  endtask

  // Monitor A: full per-pixel stream once vsync starts with expectations queued.
  bit armed_a = 1'b0, prev_done_a = 1'b0;
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed_a = 1'b0;
        prev_done_a = 1'b0;
      end else begin
        if (prev_done_a) chk("a_done_width", {31'd0, a_done}, 32'd0);
        if (a_done) begin
          if (qfc_a.size() == 0) chk("a_done_unexpected", 32'd1, 32'd0);
          else chk("a_frame_cnt", {16'd0, a_fc}, {16'd0, qfc_a.pop_front()});
        end
        prev_done_a = a_done;
        if (a_cclk) begin
          if (!armed_a && a_vs && qa.size() > 0) armed_a = 1'b1;
          if (armed_a) begin
            if (qa.size() == 0) armed_a = 1'b0;
            else begin
              it = qa.pop_front();
              chk("a_stream", {22'd0, a_vs, a_hr, a_d}, {22'd0, it});
            end
          end
        end
      end
    end
  end

  // Monitor B: RGB565 bytes on href, vsync length, frame count.
  int vrun_b = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b_done) begin
          if (qfc_b.size() == 0) chk("b_done_unexpected", 32'd1, 32'd0);
          else chk("b_frame_cnt", {16'd0, b_fc}, {16'd0, qfc_b.pop_front()});
        end
        if (b_cclk) begin
          if (b_hr) begin
            if (qb.size() == 0) chk("b_extra_byte", 32'd1, 32'd0);
            else chk("b_data", {24'd0, b_d}, {24'd0, qb.pop_front()});
          end
          if (b_vs) vrun_b++;
          else if (vrun_b > 0) begin
            chk("b_vsync_len", 32'(vrun_b), 32'd18);
            vrun_b = 0;
          end
        end
      end
    end
  end

  // Monitor C: checkerboard bytes and per-frame CRC.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (c_done) begin
          if (qcrc.size() == 0 || qfc_c.size() == 0) chk("c_done_unexpected", 32'd1, 32'd0);
          else begin
            chk("c_crc", {16'd0, c_crc}, {16'd0, qcrc.pop_front()});
            chk("c_frame_cnt", {16'd0, c_fc}, {16'd0, qfc_c.pop_front()});
          end
        end
        if (c_cclk && c_hr) begin
          if (qc.size() == 0) chk("c_extra_byte", 32'd1, 32'd0);
          else chk("c_data", {24'd0, c_d}, {24'd0, qc.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [15:0] crc;
    logic [7:0] b;
    int vcnt;
    rst_n = 1'b0;
    ea = 1'b0; eb = 1'b0; ec = 1'b0;
    ma = 2'd0; mb = 2'd0; mc = 2'd0;
    repeat (3) @(negedge clk);

    chk("rst_cam_clk", {31'd0, a_cclk}, 32'd0);
    chk("rst_vsync", {31'd0, a_vs}, 32'd0);
    chk("rst_href", {31'd0, a_hr}, 32'd0);
    chk("rst_data", {24'd0, a_d}, 32'd0);
    chk("rst_frame_cnt", {16'd0, a_fc}, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_crc", {16'd0, a_crc}, 32'd0);

    // A: ramp frame, then checkerboard (zero at 4x2), then ramp again at frame_cnt 2.
    push_a_frame(32'h03020100, 32'h04030201);
    push_a_frame(32'h00000000, 32'h00000000);
    push_a_frame(32'h05040302, 32'h06050403);
    qfc_a.push_back(16'd1); qfc_a.push_back(16'd2); qfc_a.push_back(16'd3);

    for (int l = 0; l < 2; l++) begin
      qb.push_back(8'h00); qb.push_back(8'h00); qb.push_back(8'h00); qb.push_back(8'h1F);
      qb.push_back(8'h07); qb.push_back(8'hE0); qb.push_back(8'h07); qb.push_back(8'hFF);
      qb.push_back(8'hF8); qb.push_back(8'h00); qb.push_back(8'hF8); qb.push_back(8'h1F);
      qb.push_back(8'hFF); qb.push_back(8'hE0); qb.push_back(8'hFF); qb.push_back(8'hFF);
    end
    qfc_b.push_back(16'd1);

    for (int f = 0; f < 2; f++) begin
      crc = 16'hFFFF;
      for (int l = 0; l < 16; l++)
        for (int c = 0; c < 16; c++) begin
          b = (((c >> 3) ^ (l >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
          qc.push_back(b);
          crc = crc_upd(crc, b);
        end
`ifdef CAM_STREAM_GEN_CRC_EN
      qcrc.push_back(crc);
`else
      qcrc.push_back(16'h0000);
`endif
      qfc_c.push_back(16'(f + 1));
    end

    ma = 2'd1; mb = 2'd0; mc = 2'd2;
    ea = 1'b1; eb = 1'b1; ec = 1'b1;
    rst_n = 1'b1;

    fork
      begin : a_seq
        wait_ev(1, 200, "a_href0_timeout");
        ma = 2'd2;
        wait_ev(0, 200, "a_done1_timeout");
        ma = 2'd1;
        wait_ev(0, 200, "a_done2_timeout");
        wait_ev(1, 200, "a_href2_timeout");
        repeat (2) @(negedge clk);
        ea = 1'b0;
        wait_ev(0, 200, "a_done3_timeout");
        vcnt = 0;
        repeat (40) begin
          @(negedge clk);
          if (a_vs) vcnt++;
        end
        chk("a_idle_vsync", 32'(vcnt), 32'd0);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
      end
      begin : b_seq
        wait_ev(4, 100, "b_vsync_timeout");
        eb = 1'b0;
        wait_ev(3, 400, "b_done_timeout");
        @(negedge clk);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
      end
      begin : c_seq
        wait_ev(5, 1500, "c_done1_timeout");
        ec = 1'b0;
        wait_ev(5, 1500, "c_done2_timeout");
        @(negedge clk);
        chk("c_queue_drained", 32'(qc.size()), 32'd0);
      end
    join

    // Asynchronous reset in the middle of an active line.
    ea = 1'b1;
    ma = 2'd1;
    wait_ev(1, 200, "a_href3_timeout");
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cam_clk", {31'd0, a_cclk}, 32'd0);
    chk("arst_href", {31'd0, a_hr}, 32'd0);
    chk("arst_data", {24'd0, a_d}, 32'd0);
    chk("arst_frame_cnt", {16'd0, a_fc}, 32'd0);
    push_a_frame(32'h03020100, 32'h04030201);
    qfc_a.push_back(16'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ev(2, 20, "a_vsync_restart_timeout");
    ea = 1'b0;
    wait_ev(0, 200, "a_done_restart_timeout");
    repeat (10) @(negedge clk);
    chk("a_restart_drained", 32'(qa.size() + qfc_a.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
